// File: rtl/mpdmac_cfg.sv
// APB configuration block for the matrix DMAC: base addresses, width, start pulse, status and done interrupt.
// Optional interrupt logic is built only when MPDMAC_CFG_IRQ_EN is defined.
module mpdmac_cfg #(
    parameter logic [31:0] VERSION = 32'h0001_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [11:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [5:0]  mat_width_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 6;

    localparam logic [AW-1:0] ADDR_VERSION   = 12'h000;
    localparam logic [AW-1:0] ADDR_SRC       = 12'h100;
    localparam logic [AW-1:0] ADDR_DST       = 12'h104;
    localparam logic [AW-1:0] ADDR_WIDTH     = 12'h108;
    localparam logic [AW-1:0] ADDR_START     = 12'h10C;
    localparam logic [AW-1:0] ADDR_STATUS    = 12'h110;
    localparam logic [AW-1:0] ADDR_IRQ_EN    = 12'h114;
    localparam logic [AW-1:0] ADDR_IRQ_STS   = 12'h118;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          seen_low_q, seen_low_d;
    logic [DW-1:0] src_q, src_d;
    logic [DW-1:0] dst_q, dst_d;
    logic [WW-1:0] width_q, width_d;
    logic          start_q, start_d;
    logic [DW-1:0] prdata_q, prdata_d;

    logic          setup_rd_c;
    logic          access_wr_c;
    logic          start_req_c;
    logic          done_evt_c;
    logic [DW-1:0] rdata_c;
    logic          irq_en_rd_c;
    logic          irq_sts_rd_c;

    assign setup_rd_c  = psel_i & ~penable_i & ~pwrite_i;
    assign access_wr_c = psel_i & penable_i & pwrite_i;

    // Start is accepted only from an idle engine and never back-to-back with a pending pulse.
    assign start_req_c = access_wr_c & (paddr_i == ADDR_START) & pwdata_i[0] & done_i
                       & (state_q == ST_IDLE) & ~start_q;

    // Completion is the first done_i high after the engine has visibly dropped it.
    assign done_evt_c  = (state_q == ST_BUSY) & seen_low_q & done_i;

    assign pready_o    = 1'b1;
    assign pslverr_o   = 1'b0;
    assign prdata_o    = prdata_q;
    assign src_addr_o  = src_q;
    assign dst_addr_o  = dst_q;
    assign mat_width_o = width_q;
    assign start_o     = start_q;

    always_comb begin
        rdata_c = '0;
        case (paddr_i)
            ADDR_VERSION: rdata_c = VERSION;
            ADDR_SRC:     rdata_c = src_q;
            ADDR_DST:     rdata_c = dst_q;
            ADDR_WIDTH:   rdata_c = DW'(width_q);
            ADDR_STATUS:  rdata_c = DW'(done_i);
            ADDR_IRQ_EN:  rdata_c = DW'(irq_en_rd_c);
            ADDR_IRQ_STS: rdata_c = DW'(irq_sts_rd_c);
            default:      rdata_c = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q;
        src_d      = src_q;
        dst_d      = dst_q;
        width_d    = width_q;
        prdata_d   = prdata_q;
        start_d    = start_req_c;

        if (setup_rd_c) begin
            prdata_d = rdata_c;
        end

        // Engine parameters are frozen while a transfer is in flight.
        if (access_wr_c && done_i) begin
            case (paddr_i)
                ADDR_SRC:   src_d   = pwdata_i;
                ADDR_DST:   dst_d   = pwdata_i;
                ADDR_WIDTH: width_d = pwdata_i[WW-1:0];
                default:    ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d    = ST_BUSY;
                    seen_low_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (!done_i) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d    = ST_IDLE;
                    seen_low_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                seen_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seen_low_q <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            width_q    <= '0;
            start_q    <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            seen_low_q <= seen_low_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            width_q    <= width_d;
            start_q    <= start_d;
            prdata_q   <= prdata_d;
        end
    end

`ifdef MPDMAC_CFG_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_sts_q, irq_sts_d;
    logic irq_q, irq_d;

    assign irq_en_rd_c  = irq_en_q;
    assign irq_sts_rd_c = irq_sts_q;
    assign irq_o        = irq_q;

    // A done event in the same cycle as a W1C leaves the status set.
    always_comb begin
        irq_en_d  = irq_en_q;
        irq_sts_d = irq_sts_q;
        if (access_wr_c && (paddr_i == ADDR_IRQ_EN)) begin
            irq_en_d = pwdata_i[0];
        end
        if (access_wr_c && (paddr_i == ADDR_IRQ_STS) && pwdata_i[0]) begin
            irq_sts_d = 1'b0;
        end
        if (done_evt_c) begin
            irq_sts_d = 1'b1;
        end
        irq_d = irq_sts_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q  <= 1'b0;
            irq_sts_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_d;
            irq_sts_q <= irq_sts_d;
            irq_q     <= irq_d;
        end
    end
`else
    assign irq_en_rd_c  = 1'b0;
    assign irq_sts_rd_c = 1'b0;
    assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mpdmac_cfg.sv
// Scoreboard bench for mpdmac_cfg: directed scenarios followed by random APB traffic against a register-level model.
module tb_mpdmac_cfg;

`ifdef MPDMAC_CFG_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic [11:0] paddr_i = '0;
    logic        pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [5:0]  mat_width_o;
    logic        start_o;
    logic        done_i = 1'b1;
    logic        irq_o;

    mpdmac_cfg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel_i),
        .penable_i  (penable_i),
        .paddr_i    (paddr_i),
        .pwrite_i   (pwrite_i),
        .pwdata_i   (pwdata_i),
        .pready_o   (pready_o),
        .prdata_o   (prdata_o),
        .pslverr_o  (pslverr_o),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .mat_width_o(mat_width_o),
        .start_o    (start_o),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    // Reference model of the programmer-visible state.
    logic [31:0] m_src, m_dst;
    logic [5:0]  m_w;
    bit          m_en, m_st, m_busy, m_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h000: return 32'h0001_2024;
            12'h100: return m_src;
            12'h104: return m_dst;
            12'h108: return {26'd0, m_w};
            12'h110: return {31'd0, done_i};
            12'h114: return {31'd0, m_en};
            12'h118: return {31'd0, m_st};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_w = '0;
        m_en = 0; m_st = 0; m_busy = 0; m_seen = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_src"}, src_addr_o, m_src);
        chk({tag, "_dst"}, dst_addr_o, m_dst);
        chk({tag, "_width"}, 32'(mat_width_o), 32'(m_w));
        chk({tag, "_irq"}, 32'(irq_o), 32'(m_st & m_en));
    endtask

    // Monitor: every read access phase must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && psel_i && penable_i && !pwrite_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected none", prdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (prdata_o !== mon_e || pready_o !== 1'b1 || pslverr_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_data @%h: got %h rdy=%b err=%b expected %h",
                             paddr_i, prdata_o, pready_o, pslverr_o, mon_e);
                end
            end
        end
    end

    task automatic apb_read(input logic [11:0] a);
        exp_q.push_back(model_read(a));
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a;
        @(posedge clk); #1 penable_i = 1;
        @(posedge clk); #1 psel_i = 0; penable_i = 0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input bit raise);
        bit pulse;
        bit dn;
        pulse = 0;
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d;
        @(posedge clk); #1 penable_i = 1;
        if (raise) done_i = 1;
        @(posedge clk);
        dn = done_i;
        case (a)
            12'h100: if (dn) m_src = d;
            12'h104: if (dn) m_dst = d;
            12'h108: if (dn) m_w = d[5:0];
            12'h10C: if (d[0] && dn && !m_busy) begin pulse = 1; m_busy = 1; m_seen = 0; end
            12'h114: if (IRQ) m_en = d[0];
            12'h118: if (IRQ && d[0]) m_st = 0;
            default: ;
        endcase
        if (raise && m_busy && m_seen) begin
            m_busy = 0; m_seen = 0;
            if (IRQ) m_st = 1;
        end
        #1 psel_i = 0; penable_i = 0; pwrite_i = 0;
        @(negedge clk);
        chk("start_pulse", 32'(start_o), 32'(pulse));
        check_outs("wr");
        @(negedge clk);
        chk("start_low", 32'(start_o), 32'd0);
    endtask

    task automatic set_done(input bit v);
        done_i = v;
        repeat (3) @(negedge clk);
        if (m_busy) begin
            if (!v) m_seen = 1;
            else if (m_seen) begin
                m_busy = 0; m_seen = 0;
                if (IRQ) m_st = 1;
            end
        end
        chk("done_irq", 32'(irq_o), 32'(m_st & m_en));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [8];
        logic [11:0] a;
        logic [31:0] d;
        int op;
        addrs[0] = 12'h000; addrs[1] = 12'h100; addrs[2] = 12'h104; addrs[3] = 12'h108;
        addrs[4] = 12'h10C; addrs[5] = 12'h110; addrs[6] = 12'h114; addrs[7] = 12'h118;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_pready", 32'(pready_o), 32'd1);
        check_outs("rst");
        rst_n = 1;
        @(negedge clk);

        apb_read(12'h000);
        apb_read(12'h110);
        apb_read(12'h100);

        apb_write(12'h100, 32'h0000_1000, 0);
        apb_write(12'h104, 32'h0000_2000, 0);
        apb_write(12'h108, 32'h0000_00FF, 0);
        apb_read(12'h108);
        apb_read(12'h10C);
        apb_read(12'h7FC);

        apb_write(12'h10C, 32'h1, 0);
        set_done(0);
        apb_write(12'h100, 32'h0000_5555, 0);
        apb_write(12'h10C, 32'h1, 0);
        set_done(1);
        apb_read(12'h100);

        apb_write(12'h114, 32'h1, 0);
        apb_write(12'h10C, 32'h1, 0);
        set_done(0);
        set_done(1);
        apb_read(12'h118);
        apb_write(12'h118, 32'h1, 0);
        apb_read(12'h118);
        apb_write(12'h10C, 32'h1, 0);
        set_done(0);
        apb_write(12'h118, 32'h1, 1);
        apb_read(12'h118);

        // Reset while busy with the interrupt pending.
        apb_write(12'h10C, 32'h1, 0);
        apb_write(12'h10C, 32'h1, 0);
        set_done(0);
        apb_read(12'h100);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_prdata", prdata_o, 32'd0);
        chk("arst_start", 32'(start_o), 32'd0);
        check_outs("arst");
        @(negedge clk); rst_n = 1;
        set_done(1);

        // Reset landing on a pending start pulse.
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 12'h10C; pwdata_i = 32'h1;
        @(posedge clk); #1 penable_i = 1;
        @(posedge clk); #2 rst_n = 0;
        #1 chk("arst_pulse", 32'(start_o), 32'd0);
        psel_i = 0; penable_i = 0; pwrite_i = 0;
        model_reset();
        @(negedge clk); rst_n = 1;
        apb_write(12'h10C, 32'h1, 0);
        set_done(0);
        set_done(1);

        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 7)];
            d  = $urandom;
            if (op <= 3) apb_write(a, d, 0);
            else if (op <= 6) apb_read(a);
            else set_done(1'($urandom_range(0, 1)));
        end

        set_done(1);
        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
